// File: rtl/hex_sr_ctrl.sv
// Slot read/write controller for a LENGTH-stage 6-bit recirculating shift register; zeroes every slot after reset.
// Response 1 cycle after the addressed slot passes sr_data_out (1 cycle after accept for a bad address); one command at a time, no response backpressure.
module hex_sr_ctrl #(
   parameter int LENGTH = 55,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [5:0]        cmd_data,
   output logic              rsp_valid,
   output logic [5:0]        rsp_data,
   output logic              rsp_err,
   output logic              sr_recirc,
   output logic [5:0]        sr_data_in,
   input  logic [5:0]        sr_data_out
);

   typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LENGTH - 1);
   localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(LENGTH);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pos, pos_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic              write_q, write_nxt;
   logic [5:0]        data_q, data_nxt;
   logic              err_q, err_nxt;
   logic              hs;
   logic              in_range;
   logic              hit;
   logic              rd_hit;
   logic              wr_hit_nxt;

   always_comb begin
      state_nxt  = state;
      addr_nxt   = addr_q;
      write_nxt  = write_q;
      data_nxt   = data_q;
      err_nxt    = err_q;
      hs         = cmd_valid & cmd_ready;
      in_range   = ({1'b0, cmd_addr} < LIMIT);
      hit        = (state == WAIT) && (pos == addr_q);
      rd_hit     = hit && !write_q;
      pos_nxt    = (pos == LAST) ? '0 : pos + ADDR_W'(1);

      case (state)
         INIT: begin
            if (pos == LAST) state_nxt = IDLE;
         end
         IDLE: begin
            if (hs) begin
               addr_nxt  = cmd_addr;
               write_nxt = cmd_write;
               data_nxt  = cmd_data;
               err_nxt   = !in_range;
               state_nxt = in_range ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (hit) state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = INIT;
         end
      endcase

      // Outputs are registered, so the write strobe is decided one cycle ahead
      // from the state and position the controller is about to enter.
      wr_hit_nxt = (state_nxt == WAIT) && (pos_nxt == addr_nxt) && write_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         pos        <= '0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         data_q     <= '0;
         err_q      <= 1'b0;
         cmd_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         sr_recirc  <= 1'b0;
         sr_data_in <= '0;
      end else begin
         state      <= state_nxt;
         pos        <= pos_nxt;
         addr_q     <= addr_nxt;
         write_q    <= write_nxt;
         data_q     <= data_nxt;
         err_q      <= err_nxt;
         cmd_ready  <= (state_nxt == IDLE);
         rsp_valid  <= (state_nxt == RESP);
         rsp_err    <= (state_nxt == RESP) && err_nxt;
         // Only a read match ever loads data, so writes and errors respond with 0.
         rsp_data   <= rd_hit ? sr_data_out : '0;
         sr_recirc  <= (state_nxt != INIT) && !wr_hit_nxt;
         sr_data_in <= wr_hit_nxt ? data_nxt : '0;
      end
   end

endmodule

// File: tb/tb_hex_sr_ctrl.sv
// Bench for hex_sr_ctrl: drives commands against a behavioural shift register and
// compares every response with a slot-array reference model.
module tb_hex_sr_ctrl;

   localparam int L  = 55;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [5:0]    cmd_data = '0;
   logic          cmd_ready, rsp_valid, rsp_err, sr_recirc;
   logic [5:0]    rsp_data, sr_data_in, sr_data_out;

   int errors = 0;
   int checks = 0;
   int pos_m  = 0;

   logic [5:0] sr  [L];
   logic [5:0] mem [L];

   always #5 clk = ~clk;

   hex_sr_ctrl #(.LENGTH(L), .ADDR_W(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .sr_recirc  (sr_recirc),
      .sr_data_in (sr_data_in),
      .sr_data_out(sr_data_out)
   );

   // 55-stage recirculating shift register; stage L-1 is the output.
   assign sr_data_out = sr[L-1];
   always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= sr_recirc ? sr[L-1] : sr_data_in;
   end

   always @(posedge clk) pos_m <= reset ? 0 : (pos_m + 1) % L;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
      $fatal(1);
   end

   // Slots whose physical stage disagrees with the reference slot array.
   function automatic int image_bad();
      int n = 0;
      for (int k = 0; k < L; k++)
         if (sr[L-1-((k - pos_m + L) % L)] !== mem[k]) n++;
      return n;
   endfunction

   function automatic string show(input logic [17:0] v);
      return $sformatf("data=%h err=%b lat=%0d recirc_low_cycles=%0d pulse_ok=%b",
                       v[17:12], v[11], v[10:3], v[2:1], v[0]);
   endfunction

   task automatic clear_model();
      for (int k = 0; k < L; k++) mem[k] = 6'd0;
   endtask

   task automatic model_cmd(input logic wr, input int addr, input logic [5:0] data, input int p,
                            output logic [5:0] ed, output logic ee, output int el, output int elows);
      ee    = (addr >= L);
      ed    = (wr || ee) ? 6'd0 : mem[addr];
      el    = ee ? 1 : ((addr - p - 1 + L) % L) + 2;
      elows = (wr && !ee) ? 1 : 0;
      if (wr && !ee) mem[addr] = data;
   endtask

   task automatic do_cmd(input logic wr, input int addr, input logic [5:0] data, input int want_pos,
                         output logic [5:0] rd, output logic er, output int lat, output int p,
                         output int lows, output logic ok);
      int guard = 0;
      while (!(cmd_ready === 1'b1 && (want_pos < 0 || pos_m == want_pos)) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) begin
         checks++;
         errors++;
         $display("FAIL cmd_accept: cmd_ready=%b never usable at pos %0d", cmd_ready, want_pos);
      end
      p = pos_m;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = AW'(addr);
      cmd_data  = data;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
      lat  = 1;
      lows = 0;
      forever begin
         if (sr_recirc !== 1'b1) lows++;
         if (rsp_valid === 1'b1 || lat >= 200) break;
         @(negedge clk);
         lat++;
      end
      rd = rsp_data;
      er = rsp_err;
      ok = (cmd_ready === 1'b0);
      @(negedge clk);
      ok = ok && (rsp_valid === 1'b0) && (cmd_ready === 1'b1) && (rsp_err === 1'b0) && (rsp_data === 6'd0);
   endtask

   task automatic issue(input logic wr, input int addr, input logic [5:0] data, input int want_pos,
                        output logic [17:0] got, output logic [17:0] exp);
      logic [5:0] rd, ed;
      logic er, ee, ok;
      int lat, p, lows, el, elows;
      do_cmd(wr, addr, data, want_pos, rd, er, lat, p, lows, ok);
      model_cmd(wr, addr, data, p, ed, ee, el, elows);
      got = {rd, er, lat[7:0], lows[1:0], ok};
      exp = {ed, ee, el[7:0], elows[1:0], 1'b1};
   endtask

   task automatic wait_init(output int n, output logic bad);
      n   = 0;
      bad = 1'b0;
      while (cmd_ready !== 1'b1 && n < 200) begin
         if (rsp_valid !== 1'b0 || sr_recirc !== 1'b0 || sr_data_in !== 6'd0) bad = 1'b1;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int n;
      logic bad;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, rsp_err, sr_recirc} !== 4'b0 || rsp_data !== 6'd0 || sr_data_in !== 6'd0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b valid=%b err=%b recirc=%b data=%h din=%h, required all 0",
                  cmd_ready, rsp_valid, rsp_err, sr_recirc, rsp_data, sr_data_in);
      end
      reset = 1'b0;
      wait_init(n, bad);
      clear_model();
      checks++;
      if (n != L) begin
         errors++;
         $display("FAIL init_length: %0d cycles before cmd_ready, required %0d", n, L);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL init_outputs: rsp_valid/sr_recirc/sr_data_in nonzero during INIT, required 0");
      end
      checks++;
      if (image_bad() != 0) begin
         errors++;
         $display("FAIL init_image: %0d slots nonzero after INIT, required 0", image_bad());
      end
   endtask

   task automatic test_init_read();
      logic [17:0] got, exp;
      for (int i = 0; i < 4; i++) begin
         int a = $urandom_range(0, L - 1);
         issue(1'b0, a, 6'd0, -1, got, exp);
         checks++;
         if (got !== exp || got[17:12] !== 6'd0) begin
            errors++;
            $display("FAIL init_read slot %0d: got %s, required %s", a, show(got), show(exp));
         end
      end
   endtask

   task automatic test_write_read();
      logic [17:0] got, exp;
      issue(1'b1, 5, 6'h2A, -1, got, exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL write_slot5: got %s, required %s", show(got), show(exp));
      end
      issue(1'b0, 5, 6'd0, -1, got, exp);
      checks++;
      if (got !== exp || got[17:12] !== 6'h2A) begin
         errors++;
         $display("FAIL read_slot5: got %s, required %s", show(got), show(exp));
      end
      issue(1'b0, 6, 6'd0, -1, got, exp);
      checks++;
      if (got !== exp || got[17:12] !== 6'd0) begin
         errors++;
         $display("FAIL read_slot6: got %s, required %s", show(got), show(exp));
      end
   endtask

   task automatic test_latency();
      logic [17:0] got, exp;
      issue(1'b0, 11, 6'd0, 10, got, exp);
      checks++;
      if (got !== exp || got[10:3] !== 8'd2) begin
         errors++;
         $display("FAIL latency_next_slot: got %s, required %s", show(got), show(exp));
      end
      issue(1'b0, 10, 6'd0, 10, got, exp);
      checks++;
      if (got !== exp || got[10:3] !== 8'd56) begin
         errors++;
         $display("FAIL latency_full_turn: got %s, required %s", show(got), show(exp));
      end
   endtask

   task automatic test_error();
      logic [17:0] got, exp;
      int bad_addr [4] = '{55, 63, 55, 63};
      for (int i = 0; i < 4; i++) begin
         issue(i[0] == 1'b0, bad_addr[i], 6'h3F, -1, got, exp);
         checks++;
         if (got !== exp || got[11] !== 1'b1 || got[10:3] !== 8'd1 || got[2:1] !== 2'd0) begin
            errors++;
            $display("FAIL error_addr %0d: got %s, required %s", bad_addr[i], show(got), show(exp));
         end
      end
      checks++;
      if (image_bad() != 0) begin
         errors++;
         $display("FAIL error_image: %0d slots differ from model, required 0", image_bad());
      end
   endtask

   task automatic test_back_to_back();
      logic [17:0] got, exp;
      for (int i = 0; i < 6; i++) begin
         int a = (i % 3 == 0) ? 60 : (pos_m + 1) % L;
         issue(i % 2 == 1, a, 6'(i * 9 + 1), -1, got, exp);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL back_to_back %0d addr %0d: got %s, required %s", i, a, show(got), show(exp));
         end
      end
   endtask

   task automatic test_all_slots();
      logic [17:0] got, exp;
      logic [5:0] d [L];
      int r = $urandom_range(0, 63);
      for (int k = 0; k < L; k++) d[k] = 6'((k * 37 + r) % 64);
      issue(1'b1, 0, d[0], L - 1, got, exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL wrap_write0: got %s, required %s", show(got), show(exp));
      end
      issue(1'b1, L - 1, d[L-1], 0, got, exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL wrap_write54: got %s, required %s", show(got), show(exp));
      end
      for (int k = 1; k < L - 1; k++) begin
         issue(1'b1, k, d[k], -1, got, exp);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL all_write slot %0d: got %s, required %s", k, show(got), show(exp));
         end
      end
      checks++;
      if (image_bad() != 0) begin
         errors++;
         $display("FAIL all_image: %0d slots differ from model, required 0", image_bad());
      end
      for (int k = 0; k < L; k++) begin
         int want = (k == 0) ? L - 1 : (k == L - 1) ? L - 2 : -1;
         issue(1'b0, k, 6'd0, want, got, exp);
         checks++;
         if (got !== exp || got[17:12] !== d[k]) begin
            errors++;
            $display("FAIL all_read slot %0d: got %s, required %s", k, show(got), show(exp));
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [17:0] got, exp;
      int n;
      int guard = 0;
      logic bad;
      issue(1'b1, 40, 6'h33, -1, got, exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL abort_prewrite: got %s, required %s", show(got), show(exp));
      end
      while (!(cmd_ready === 1'b1 && pos_m == 41) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 6'd40;
      cmd_data  = 6'h15;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (guard >= 200 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_wait: guard=%0d ready=%b valid=%b, required ready=0 valid=0", guard, cmd_ready, rsp_valid);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_init(n, bad);
      clear_model();
      checks++;
      if (n != L) begin
         errors++;
         $display("FAIL abort_init_length: %0d cycles, required %0d", n, L);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL abort_no_rsp: rsp_valid or SR drive active during INIT, required 0");
      end
      issue(1'b0, 40, 6'd0, -1, got, exp);
      checks++;
      if (got !== exp || got[17:12] !== 6'd0) begin
         errors++;
         $display("FAIL abort_read40: got %s, required %s", show(got), show(exp));
      end
   endtask

   task automatic test_random();
      logic [17:0] got, exp;
      for (int i = 0; i < 60; i++) begin
         int a = ($urandom_range(0, 9) == 0) ? $urandom_range(L, 63) : $urandom_range(0, L - 1);
         logic wr = 1'($urandom_range(0, 1));
         logic [5:0] dv = 6'($urandom_range(0, 63));
         issue(wr, a, dv, -1, got, exp);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random %0d wr=%b addr=%0d: got %s, required %s", i, wr, a, show(got), show(exp));
         end
      end
      checks++;
      if (image_bad() != 0) begin
         errors++;
         $display("FAIL random_image: %0d slots differ from model, required 0", image_bad());
      end
   endtask

   initial begin
      test_reset();
      test_init_read();
      test_write_read();
      test_latency();
      test_error();
      test_back_to_back();
      test_all_slots();
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hex_sr_ctrl.md
HEX_SR_CTRL -- requirements
Module: hex_sr_ctrl

Interface
REQ-001 Parameter LENGTH, default 55, SHALL set the stage count of the attached 6-bit recirculating shift register, which is also the slot count.
REQ-002 Parameter ADDR_W, default 6, SHALL set the slot address width; ceil(log2(LENGTH)) <= ADDR_W is required.
REQ-003 clk  input  1  SHALL be the single clock, shared with the attached shift register, which shifts on every rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 cmd_valid  input  1  SHALL mean that a command is offered.
REQ-006 cmd_ready  output  1  SHALL mean that the controller accepts a command this cycle.
REQ-007 cmd_write  input  1  SHALL select write (1) or read (0).
REQ-008 cmd_addr  input  ADDR_W  SHALL carry the slot index.
REQ-009 cmd_data  input  6  SHALL carry the write data.
REQ-010 rsp_valid  output  1  SHALL be a one-cycle completion pulse; there is no backpressure.
REQ-011 rsp_data  output  6  SHALL return read data; it is 0 for writes and for errors.
REQ-012 rsp_err  output  1  SHALL flag an out-of-range address and is qualified by rsp_valid.
REQ-013 sr_recirc  output  1  SHALL drive the shift register's recirculate input (1 = recirculate, 0 = load sr_data_in).
REQ-014 sr_data_in  output  6  SHALL drive the shift register's data input.
REQ-015 sr_data_out  input  6  SHALL be the shift register's data output.

Function
REQ-016 A position counter pos SHALL advance by one every cycle and wrap from LENGTH-1 to 0; the word on sr_data_out while pos==k is slot k.
REQ-017 The FSM SHALL have exactly four states: INIT, IDLE, WAIT, RESP.
REQ-018 INIT SHALL drive sr_recirc=0 and sr_data_in=0 for LENGTH cycles (pos 0..LENGTH-1), hold cmd_ready=0, and go to IDLE when pos wraps to 0.
REQ-019 IDLE SHALL drive cmd_ready=1 and sr_recirc=1; a handshake (cmd_valid & cmd_ready) SHALL latch cmd_write, cmd_addr and cmd_data.
REQ-020 In IDLE, a handshake with cmd_addr < LENGTH SHALL move to WAIT; with cmd_addr >= LENGTH it SHALL move to RESP with the error flag set and no shift-register access.
REQ-021 WAIT SHALL drive cmd_ready=0 and compare pos with the latched address every cycle, including the first WAIT cycle.
REQ-022 On a WAIT match with write: drive sr_recirc=0 and sr_data_in=latched data for exactly that cycle, then go to RESP.
REQ-023 On a WAIT match with read: register sr_data_out into rsp_data, keep sr_recirc=1, then go to RESP.
REQ-024 On any cycle without a write match, sr_recirc SHALL be 1 (except in INIT) and sr_data_in SHALL be 0.
REQ-025 RESP SHALL assert rsp_valid=1 for one cycle with rsp_err and rsp_data per REQ-011 and REQ-012, drive cmd_ready=0, then return to IDLE.
REQ-026 Latency: a command accepted at pos=p SHALL reach its WAIT match at offset ((addr-p-1) mod LENGTH)+1 cycles (range 1..LENGTH), and rsp_valid SHALL follow one cycle after the match; an error response SHALL come exactly 1 cycle after accept.
REQ-027 At most one command SHALL be outstanding; back-to-back commands SHALL have at least 1 idle-ready cycle between responses.
REQ-028 sr_recirc, sr_data_in, cmd_ready and rsp_* SHALL be driven from registered state only, with no combinational path from cmd_* inputs.
REQ-029 A read after a write to the same slot SHALL return the written value; the other LENGTH-1 slots SHALL be unchanged.

Reset
REQ-030 reset=1 at a clock edge SHALL set pos=0, state=INIT, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, sr_recirc=0 and sr_data_in=0.
REQ-031 Reset in WAIT or RESP SHALL abort the command with no rsp_valid; INIT then rewrites all slots to 0.
REQ-032 Reset asserted for several cycles SHALL hold pos=0 and INIT; counting starts on the first cycle after release.

Verification
REQ-033 Release reset with LENGTH=55: cmd_ready=0, sr_recirc=0 and sr_data_in=0 for 55 cycles, then cmd_ready=1; a subsequent read of any slot returns 0x00.
REQ-034 Write slot 5 with 0x2A, then read slot 5: rsp_valid with rsp_data=0x2A and rsp_err=0; a read of slot 6 returns 0x00.
REQ-035 Accept a read at pos=10: addr=11 gives rsp_valid 2 cycles after accept; addr=10 gives rsp_valid 56 cycles after accept.
REQ-036 Command with addr=55 or 63: rsp_valid and rsp_err=1 one cycle after accept, rsp_data=0, sr_recirc stays 1, no slot changes.
REQ-037 Assert reset for 1 cycle during WAIT of a write to slot 40: no rsp_valid, a full 55-cycle INIT follows, and slot 40 then reads 0x00.
REQ-038 Bench SHALL include a behavioural 55-stage 6-bit recirculating shift-register model and check write/read of all 55 slots with distinct data, including slots 0 and 54 around the pos wrap.
